// File: rtl/lsu_mem_ctrl_pkg.sv
// rtl/lsu_mem_ctrl_pkg.sv - shared types, constants and request checker for the LSU memory controller
//
// Purpose : funct3 codes, FSM state encoding, response error codes, bus widths
//           and the request legality check used at acceptance.
// Ports   : none (package)

package lsu_mem_ctrl_pkg;

  localparam int ADDR_WIDTH     = 32;
  localparam int MEM_ADDR_WIDTH = 30;
  localparam logic [31:0] MEM_WORDS_DEFAULT = 32'h0000_0FFF;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_WRITE   = 3'd3,
    ST_RESP    = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_RANGE    = 2'b10,
    ERR_FUNCT3   = 2'b11
  } err_t;

  // Checks are ordered: an illegal funct3 hides alignment, alignment hides range.
  function automatic err_t req_check(input logic                  store,
                                     input logic [2:0]            funct3,
                                     input logic [ADDR_WIDTH-1:0] addr,
                                     input logic [31:0]           mem_words);
    logic illegal;
    logic is_half;
    logic is_word;
    err_t err;
    illegal = store ? (funct3 > F3_W)
                    : (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7);
    is_half = (funct3[1:0] == 2'b01);
    is_word = (funct3 == F3_W);
    err = ERR_OK;
    if (illegal)
      err = ERR_FUNCT3;
    else if ((is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00)))
      err = ERR_MISALIGN;
    else if ({2'b00, addr[ADDR_WIDTH-1:2]} >= mem_words)
      err = ERR_RANGE;
    return err;
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// rtl/lsu_mem_ctrl_if.sv - request/response and data-memory bus of the LSU memory controller
//
// Purpose : bundles the core-side request/response handshake and the word-wide
//           memory bus.
// Modports: slave  - the controller (takes requests, drives the memory)
//           master - the core plus memory (issues requests, returns read data)
// Signals : lsu_req_valid/ready/store/funct3/addr/wdata, lsu_resp_valid/rdata/err,
//           lsu_busy, lsu_mem_addr/wdata/wr_en, lsu_mem_rdata

interface lsu_mem_ctrl_if;
  import lsu_mem_ctrl_pkg::*;

  logic                      lsu_req_valid;
  logic                      lsu_req_ready;
  logic                      lsu_req_store;
  logic [2:0]                lsu_req_funct3;
  logic [ADDR_WIDTH-1:0]     lsu_req_addr;
  logic [31:0]               lsu_req_wdata;
  logic                      lsu_resp_valid;
  logic [31:0]               lsu_resp_rdata;
  logic [1:0]                lsu_resp_err;
  logic                      lsu_busy;
  logic [MEM_ADDR_WIDTH-1:0] lsu_mem_addr;
  logic [31:0]               lsu_mem_wdata;
  logic                      lsu_mem_wr_en;
  logic [31:0]               lsu_mem_rdata;

  modport slave (
    input  lsu_req_valid, lsu_req_store, lsu_req_funct3, lsu_req_addr, lsu_req_wdata,
    input  lsu_mem_rdata,
    output lsu_req_ready, lsu_resp_valid, lsu_resp_rdata, lsu_resp_err, lsu_busy,
    output lsu_mem_addr, lsu_mem_wdata, lsu_mem_wr_en
  );

  modport master (
    output lsu_req_valid, lsu_req_store, lsu_req_funct3, lsu_req_addr, lsu_req_wdata,
    output lsu_mem_rdata,
    input  lsu_req_ready, lsu_resp_valid, lsu_resp_rdata, lsu_resp_err, lsu_busy,
    input  lsu_mem_addr, lsu_mem_wdata, lsu_mem_wr_en
  );

endinterface

// File: rtl/lsu_mem_ctrl_lane_align.sv
// rtl/lsu_mem_ctrl_lane_align.sv - byte/half lane extraction and store merge
//
// Purpose : combinational lane logic for the LSU.
// Ports   : mem_word   in  32  word read from memory
//           wdata      in  32  store data (low byte/half used for SB/SH)
//           byte_off   in  2   addr[1:0], little-endian lane select
//           funct3     in  3   RV32I funct3
//           load_data  out 32  extracted and sign-/zero-extended load value
//           store_word out 32  word to write back (merged for SB/SH, wdata for SW)

module lsu_lane_align
  import lsu_mem_ctrl_pkg::*;
(
  input  logic [31:0] mem_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  byte_off,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte  = 8'(mem_word >> {byte_off, 3'b000});
    sel_half  = byte_off[1] ? mem_word[31:16] : mem_word[15:0];
    load_data = '0;
    case (funct3)
      F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
      F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
      F3_W:    load_data = mem_word;
      F3_BU:   load_data = {24'h0, sel_byte};
      F3_HU:   load_data = {16'h0, sel_half};
      default: load_data = '0;
    endcase
  end

  always_comb begin
    store_word = mem_word;
    case (funct3)
      F3_B: begin
        case (byte_off)
          2'd0: store_word[7:0]   = wdata[7:0];
          2'd1: store_word[15:8]  = wdata[7:0];
          2'd2: store_word[23:16] = wdata[7:0];
          2'd3: store_word[31:24] = wdata[7:0];
        endcase
      end
      F3_H: begin
        if (byte_off[1])
          store_word[31:16] = wdata[15:0];
        else
          store_word[15:0]  = wdata[15:0];
      end
      F3_W:    store_word = wdata;
      default: store_word = mem_word;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - load/store sequencer between RV32I execute and word-wide data memory
//
// Purpose : accepts one load/store at a time, performs sub-word stores as
//           read-modify-write, returns extended load data or an error code
//           on a one-cycle response pulse.
// Ports   : lsu_clk    in  clock shared with the data memory
//           lsu_rst_n  in  asynchronous active-low reset
//           bus        slave modport of lsu_mem_ctrl_if (request, response, memory)

module lsu_mem_ctrl
  import lsu_mem_ctrl_pkg::*;
#(
  parameter logic [31:0] MEM_WORDS = MEM_WORDS_DEFAULT
) (
  input  logic          lsu_clk,
  input  logic          lsu_rst_n,
  lsu_mem_ctrl_if.slave bus
);

  state_t      state_q;
  state_t      state_d;

  logic        store_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] mem_wdata_q;
  logic [31:0] resp_rdata_q;
  err_t        resp_err_q;

  logic [31:0] resp_rdata_d;
  err_t        resp_err_d;
  err_t        req_err;
  logic        req_accept;
  logic        req_is_sw;
  logic [31:0] load_data;
  logic [31:0] merged_word;

  lsu_lane_align u_lane_align (
    .mem_word   (bus.lsu_mem_rdata),
    .wdata      (wdata_q),
    .byte_off   (addr_q[1:0]),
    .funct3     (f3_q),
    .load_data  (load_data),
    .store_word (merged_word)
  );

  assign req_accept = (state_q == ST_IDLE) && bus.lsu_req_valid;
  assign req_is_sw  = bus.lsu_req_store && (bus.lsu_req_funct3 == F3_W);

  always_ff @(posedge lsu_clk or negedge lsu_rst_n) begin
    if (!lsu_rst_n)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  // Response fields are only computed on the transition into RESP so that
  // they hold steady between pulses.
  always_comb begin
    state_d      = state_q;
    resp_rdata_d = '0;
    resp_err_d   = ERR_OK;
    req_err      = req_check(bus.lsu_req_store, bus.lsu_req_funct3,
                             bus.lsu_req_addr, MEM_WORDS);
    case (state_q)
      ST_IDLE: begin
        if (bus.lsu_req_valid) begin
          if (req_err != ERR_OK) begin
            state_d    = ST_RESP;
            resp_err_d = req_err;
          end else if (req_is_sw) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_READ:    state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        if (store_q) begin
          state_d = ST_WRITE;
        end else begin
          state_d      = ST_RESP;
          resp_rdata_d = load_data;
        end
      end
      ST_WRITE:   state_d = ST_RESP;
      ST_RESP:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge lsu_clk or negedge lsu_rst_n) begin
    if (!lsu_rst_n) begin
      store_q      <= 1'b0;
      f3_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      mem_wdata_q  <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= ERR_OK;
    end else begin
      if (req_accept) begin
        store_q <= bus.lsu_req_store;
        f3_q    <= bus.lsu_req_funct3;
        addr_q  <= bus.lsu_req_addr;
        wdata_q <= bus.lsu_req_wdata;
        // SW skips the read, so its write word must be ready by WRITE.
        if (req_is_sw)
          mem_wdata_q <= bus.lsu_req_wdata;
      end
      if (state_q == ST_CAPTURE && store_q)
        mem_wdata_q <= merged_word;
      if (state_d == ST_RESP) begin
        resp_rdata_q <= resp_rdata_d;
        resp_err_q   <= resp_err_d;
      end
    end
  end

  assign bus.lsu_req_ready  = (state_q == ST_IDLE);
  assign bus.lsu_busy       = (state_q != ST_IDLE);
  assign bus.lsu_resp_valid = (state_q == ST_RESP);
  assign bus.lsu_resp_rdata = resp_rdata_q;
  assign bus.lsu_resp_err   = resp_err_q;
  assign bus.lsu_mem_addr   = addr_q[31:2];
  assign bus.lsu_mem_wdata  = mem_wdata_q;
  // Decoded straight from the state register so reset removes it at once.
  assign bus.lsu_mem_wr_en  = (state_q == ST_WRITE);

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - self-checking bench for lsu_mem_ctrl

module tb_lsu_mem_ctrl;

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_err;
    int          exp_lat;
    int          exp_wr;
    logic [31:0] exp_mem;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  int   hi_wr;

  lsu_mem_ctrl_if bus();

  lsu_mem_ctrl #(.MEM_WORDS(32'h0000_0FFF)) dut (
    .lsu_clk   (clk),
    .lsu_rst_n (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:4095];

  always @(posedge clk) begin
    if (bus.lsu_mem_wr_en)
      mem[bus.lsu_mem_addr[11:0]] <= bus.lsu_mem_wdata;
    bus.lsu_mem_rdata <= mem[bus.lsu_mem_addr[11:0]];
  end

  initial hi_wr = 0;
  always @(posedge clk) begin
    if (bus.lsu_mem_wr_en && (bus.lsu_mem_addr[29:12] != 18'h0))
      hi_wr <= hi_wr + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic st, logic [2:0] f3, logic [31:0] a, logic [31:0] wd,
                              logic [31:0] rd, logic [1:0] er, int lat, int wr, logic [31:0] m);
    vec_t v;
    v.st = st; v.f3 = f3; v.addr = a; v.wdata = wd;
    v.exp_rdata = rd; v.exp_err = er; v.exp_lat = lat; v.exp_wr = wr; v.exp_mem = m;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.lsu_req_store  = v.st;
    bus.lsu_req_funct3 = v.f3;
    bus.lsu_req_addr   = v.addr;
    bus.lsu_req_wdata  = v.wdata;
  endtask

  // Called #1 after a posedge. Returns with time #1 after the response edge.
  task automatic do_req(input vec_t v, output int lat, output logic [31:0] rd,
                        output logic [1:0] er, output int nwr, output logic [29:0] wa,
                        output logic busy1, output logic timed_out);
    int  n;
    int  i;
    logic done;
    n = 0;
    while (!bus.lsu_req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    drive(v);
    bus.lsu_req_valid = 1'b1;
    @(posedge clk); #1;
    bus.lsu_req_valid = 1'b0;
    lat = 0; rd = 'x; er = 'x; nwr = 0; wa = '0; done = 1'b0;
    busy1 = bus.lsu_busy;
    i = 1;
    while (!done && i <= 10) begin
      if (bus.lsu_mem_wr_en) begin
        nwr++;
        wa = bus.lsu_mem_addr;
      end
      if (bus.lsu_resp_valid) begin
        lat  = i;
        rd   = bus.lsu_resp_rdata;
        er   = bus.lsu_resp_err;
        done = 1'b1;
      end else begin
        @(posedge clk); #1;
        i++;
      end
    end
    timed_out = !done;
  endtask

  vec_t        vecs[$];
  vec_t        bb[$];
  vec_t        v;
  int          lat;
  int          nwr;
  logic [31:0] rd;
  logic [1:0]  er;
  logic [29:0] wa;
  logic        busy1;
  logic        to;
  logic [31:0] bb_rd [3];
  logic [1:0]  bb_er [3];
  int          nacc, nresp, extra, held;
  logic        acc;
  logic        seen_wr;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    bus.lsu_req_valid  = 1'b0;
    bus.lsu_req_store  = 1'b0;
    bus.lsu_req_funct3 = 3'd0;
    bus.lsu_req_addr   = 32'h0;
    bus.lsu_req_wdata  = 32'h0;

    vecs.push_back(mk(1, 2, 32'h10,   32'hDEADBEEF, 32'h0,        2'd0, 2, 1, 32'hDEADBEEF));
    vecs.push_back(mk(0, 2, 32'h10,   32'h0,        32'hDEADBEEF, 2'd0, 3, 0, 32'hDEADBEEF));
    vecs.push_back(mk(1, 2, 32'h10,   32'h11223344, 32'h0,        2'd0, 2, 1, 32'h11223344));
    vecs.push_back(mk(1, 0, 32'h12,   32'h000000AA, 32'h0,        2'd0, 4, 1, 32'h11AA3344));
    vecs.push_back(mk(0, 0, 32'h12,   32'h0,        32'hFFFFFFAA, 2'd0, 3, 0, 32'h11AA3344));
    vecs.push_back(mk(0, 4, 32'h12,   32'h0,        32'h000000AA, 2'd0, 3, 0, 32'h11AA3344));
    vecs.push_back(mk(1, 2, 32'h10,   32'h11223344, 32'h0,        2'd0, 2, 1, 32'h11223344));
    vecs.push_back(mk(1, 1, 32'h12,   32'h00008001, 32'h0,        2'd0, 4, 1, 32'h80013344));
    vecs.push_back(mk(0, 1, 32'h12,   32'h0,        32'hFFFF8001, 2'd0, 3, 0, 32'h80013344));
    vecs.push_back(mk(0, 5, 32'h12,   32'h0,        32'h00008001, 2'd0, 3, 0, 32'h80013344));
    vecs.push_back(mk(0, 2, 32'h13,   32'h0,        32'h0,        2'd1, 1, 0, 32'h0));
    vecs.push_back(mk(1, 1, 32'h11,   32'h12345678, 32'h0,        2'd1, 1, 0, 32'h0));
    vecs.push_back(mk(0, 2, 32'h3FFC, 32'h0,        32'h0,        2'd2, 1, 0, 32'h0));
    vecs.push_back(mk(1, 3, 32'h10,   32'h0,        32'h0,        2'd3, 1, 0, 32'h0));
    vecs.push_back(mk(0, 6, 32'h10,   32'h0,        32'h0,        2'd3, 1, 0, 32'h0));
    vecs.push_back(mk(0, 2, 32'h3FFE, 32'h0,        32'h0,        2'd1, 1, 0, 32'h0));
    vecs.push_back(mk(1, 4, 32'h3,    32'h0,        32'h0,        2'd3, 1, 0, 32'h0));
    vecs.push_back(mk(1, 0, 32'h13,   32'h12345677, 32'h0,        2'd0, 4, 1, 32'h77013344));
    vecs.push_back(mk(0, 0, 32'h13,   32'h0,        32'h00000077, 2'd0, 3, 0, 32'h77013344));
    vecs.push_back(mk(0, 1, 32'h10,   32'h0,        32'h00003344, 2'd0, 3, 0, 32'h77013344));
    vecs.push_back(mk(0, 4, 32'h11,   32'h0,        32'h00000033, 2'd0, 3, 0, 32'h77013344));
    vecs.push_back(mk(0, 0, 32'h10,   32'h0,        32'h00000044, 2'd0, 3, 0, 32'h77013344));
    vecs.push_back(mk(1, 2, 32'h3FF8, 32'hCAFEF00D, 32'h0,        2'd0, 2, 1, 32'hCAFEF00D));
    vecs.push_back(mk(0, 2, 32'h3FF8, 32'h0,        32'hCAFEF00D, 2'd0, 3, 0, 32'hCAFEF00D));
    vecs.push_back(mk(1, 1, 32'h3FF8, 32'hFFFF1234, 32'h0,        2'd0, 4, 1, 32'hCAFE1234));
    vecs.push_back(mk(0, 5, 32'h3FFA, 32'h0,        32'h0000CAFE, 2'd0, 3, 0, 32'hCAFE1234));
    vecs.push_back(mk(0, 1, 32'h3FFA, 32'h0,        32'hFFFFCAFE, 2'd0, 3, 0, 32'hCAFE1234));

    // Reset values while reset is held
    #12;
    chk("rst ready",      {31'h0, bus.lsu_req_ready},  32'h1);
    chk("rst resp_valid", {31'h0, bus.lsu_resp_valid}, 32'h0);
    chk("rst resp_rdata", bus.lsu_resp_rdata,          32'h0);
    chk("rst resp_err",   {30'h0, bus.lsu_resp_err},   32'h0);
    chk("rst wr_en",      {31'h0, bus.lsu_mem_wr_en},  32'h0);
    chk("rst busy",       {31'h0, bus.lsu_busy},       32'h0);
    chk("rst mem_addr",   {2'b00, bus.lsu_mem_addr},   32'h0);
    chk("rst mem_wdata",  bus.lsu_mem_wdata,           32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post-rst ready", {31'h0, bus.lsu_req_ready},  32'h1);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      do_req(v, lat, rd, er, nwr, wa, busy1, to);
      chk($sformatf("v%0d timeout", i), {31'h0, to},     32'h0);
      chk($sformatf("v%0d rdata", i),   rd,              v.exp_rdata);
      chk($sformatf("v%0d err", i),     {30'h0, er},     {30'h0, v.exp_err});
      chk($sformatf("v%0d latency", i), lat,             v.exp_lat);
      chk($sformatf("v%0d wr_cycles", i), nwr,           v.exp_wr);
      chk($sformatf("v%0d busy", i),    {31'h0, busy1},  32'h1);
      if (v.exp_wr == 1)
        chk($sformatf("v%0d wr_addr", i), {2'b00, wa},   {2'b00, v.addr[31:2]});
      if (v.exp_err == 2'd0)
        chk($sformatf("v%0d mem_word", i), mem[v.addr[13:2]], v.exp_mem);
    end

    // Back-to-back with req_valid held high across three requests
    bb.push_back(mk(1, 2, 32'h20, 32'h01010101, 32'h0, 2'd0, 2, 1, 32'h0));
    bb.push_back(mk(0, 2, 32'h20, 32'h0,        32'h0, 2'd0, 3, 0, 32'h0));
    bb.push_back(mk(1, 2, 32'h20, 32'h02020202, 32'h0, 2'd0, 2, 1, 32'h0));
    for (int k = 0; k < 3; k++) begin
      bb_rd[k] = 'x;
      bb_er[k] = 'x;
    end
    @(posedge clk); #1;
    nacc = 0; nresp = 0; extra = 0; held = 0;
    drive(bb[0]);
    bus.lsu_req_valid = 1'b1;
    for (int c = 0; c < 60 && !(nacc == 3 && nresp >= 3); c++) begin
      @(negedge clk);
      if (bus.lsu_resp_valid) begin
        if (nresp < 3) begin
          bb_rd[nresp] = bus.lsu_resp_rdata;
          bb_er[nresp] = bus.lsu_resp_err;
        end else begin
          extra++;
        end
        nresp++;
      end
      acc = bus.lsu_req_valid && bus.lsu_req_ready;
      if (bus.lsu_req_valid && !bus.lsu_req_ready)
        held++;
      @(posedge clk); #1;
      if (acc) begin
        nacc++;
        if (nacc < 3) drive(bb[nacc]);
        else bus.lsu_req_valid = 1'b0;
      end
    end
    bus.lsu_req_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.lsu_resp_valid) extra++;
    end
    chk("b2b accepted",  nacc,  32'd3);
    chk("b2b responses", nresp, 32'd3);
    chk("b2b extra",     extra, 32'd0);
    chk("b2b held_off",  {31'h0, held > 0}, 32'h1);
    chk("b2b r0 rdata",  bb_rd[0], 32'h0);
    chk("b2b r1 rdata",  bb_rd[1], 32'h01010101);
    chk("b2b r2 rdata",  bb_rd[2], 32'h0);
    for (int k = 0; k < 3; k++)
      chk($sformatf("b2b r%0d err", k), {30'h0, bb_er[k]}, 32'h0);
    chk("b2b mem_word", mem[8], 32'h02020202);

    // Reset in the WRITE cycle of an SB
    @(posedge clk); #1;
    v = mk(1, 2, 32'h30, 32'h55667788, 32'h0, 2'd0, 2, 1, 32'h0);
    do_req(v, lat, rd, er, nwr, wa, busy1, to);
    chk("rst-seq setup latency", lat, 32'd2);
    chk("rst-seq setup word", mem[12], 32'h55667788);
    @(posedge clk); #1;
    drive(mk(1, 0, 32'h31, 32'h00000099, 32'h0, 2'd0, 4, 1, 32'h0));
    bus.lsu_req_valid = 1'b1;
    @(posedge clk); #1;
    bus.lsu_req_valid = 1'b0;
    seen_wr = 1'b0;
    for (int c = 0; c < 8 && !seen_wr; c++) begin
      if (bus.lsu_mem_wr_en) seen_wr = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("rst-seq reached WRITE", {31'h0, seen_wr}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst-seq wr_en", {31'h0, bus.lsu_mem_wr_en}, 32'h0);
    chk("rst-seq busy",  {31'h0, bus.lsu_busy},      32'h0);
    chk("rst-seq ready", {31'h0, bus.lsu_req_ready}, 32'h1);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    extra = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.lsu_resp_valid) extra++;
    end
    chk("rst-seq no resp", extra, 32'd0);
    chk("rst-seq word unchanged", mem[12], 32'h55667788);
    @(posedge clk); #1;
    v = mk(0, 2, 32'h30, 32'h0, 32'h55667788, 2'd0, 3, 0, 32'h0);
    do_req(v, lat, rd, er, nwr, wa, busy1, to);
    chk("rst-seq reload rdata", rd, 32'h55667788);
    chk("rst-seq reload latency", lat, 32'd3);

    chk("no high-address writes", hi_wr, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
